// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM arbiter: FSM encoding, requester IDs
// and the default read timeout.
package data_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int COUNT_WIDTH     = 4;

    // With both requesters asking, the one that was not served last wins.
    function automatic req_id_t rr_pick(input logic   req_a,
                                        input logic   req_b,
                                        input req_id_t last_grant);
        req_id_t pick;
        if (req_a && req_b) begin
            pick = (last_grant == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            pick = REQ_B;
        end else begin
            pick = REQ_A;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick between requester A and B.
module rr_arbiter2
    import data_ram_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_t last_grant,
    output req_id_t grant,
    output logic    valid
);

    always_comb begin
        valid = req_a | req_b;
        grant = rr_pick(req_a, req_b, last_grant);
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-requester arbiter in front of a single-port data RAM; serves one
// latched command at a time and reports completion with a one-cycle ack.
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter int width   = 8,
    parameter int length  = 8,
    parameter int timeout = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,

    input  logic              reqA,
    input  logic              weA,
    input  logic              indA,
    input  logic [length-1:0] addrA,
    input  logic [width-1:0]  wdataA,
    output logic              ackA,
    output logic [width-1:0]  rdataA,
    output logic              errA,

    input  logic              reqB,
    input  logic              weB,
    input  logic              indB,
    input  logic [length-1:0] addrB,
    input  logic [width-1:0]  wdataB,
    output logic              ackB,
    output logic [width-1:0]  rdataB,
    output logic              errB,

    output logic              busy,

    output logic              ramWriteEnable,
    output logic              ramReadEnable,
    output logic              ramIndirect,
    output logic [length-1:0] ramReadAddr,
    output logic [length-1:0] ramWriteAddr,
    output logic [width-1:0]  ramWriteData,
    input  logic [width-1:0]  ramReadData,
    input  logic              ramDataReady
);

    // The counter starts at 0 on WAIT entry, so the last allowed WAIT cycle
    // is the one where it reads timeout-1.
    localparam logic [COUNT_WIDTH-1:0] LAST_WAIT = COUNT_WIDTH'(timeout - 1);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] wait_count;
    req_id_t                last_grant;
    req_id_t                owner;
    logic                   op_write;

    req_id_t                arb_grant;
    logic                   arb_valid;

    logic                   sel_we;
    logic                   sel_ind;
    logic [length-1:0]      sel_addr;
    logic [width-1:0]       sel_wdata;

    logic                   finish_op;
    logic                   finish_err;
    logic                   capture;

    rr_arbiter2 u_rr_arbiter2 (
        .req_a      (reqA),
        .req_b      (reqB),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    always_comb begin
        if (arb_grant == REQ_B) begin
            sel_we    = weB;
            sel_ind   = indB;
            sel_addr  = addrB;
            sel_wdata = wdataB;
        end else begin
            sel_we    = weA;
            sel_ind   = indA;
            sel_addr  = addrA;
            sel_wdata = wdataA;
        end
    end

    // Decide whether this edge moves the FSM into DONE, and how it ends.
    always_comb begin
        finish_op  = 1'b0;
        finish_err = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_ISSUE: begin
                finish_op = op_write;
            end
            ST_WAIT: begin
                if (ramDataReady) begin
                    finish_op = 1'b1;
                    capture   = 1'b1;
                end else if (wait_count == LAST_WAIT) begin
                    finish_op  = 1'b1;
                    finish_err = 1'b1;
                end
            end
            default: begin
                finish_op = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state          <= ST_IDLE;
            wait_count     <= '0;
            last_grant     <= REQ_B;
            owner          <= REQ_A;
            op_write       <= 1'b0;
            ackA           <= 1'b0;
            ackB           <= 1'b0;
            errA           <= 1'b0;
            errB           <= 1'b0;
            rdataA         <= '0;
            rdataB         <= '0;
            busy           <= 1'b0;
            ramWriteEnable <= 1'b0;
            ramReadEnable  <= 1'b0;
            ramIndirect    <= 1'b0;
            ramReadAddr    <= '0;
            ramWriteAddr   <= '0;
            ramWriteData   <= '0;
        end else begin
            if (finish_op) begin
                if (owner == REQ_A) begin
                    ackA <= 1'b1;
                    errA <= finish_err;
                    if (capture) begin
                        rdataA <= ramReadData;
                    end
                end else begin
                    ackB <= 1'b1;
                    errB <= finish_err;
                    if (capture) begin
                        rdataB <= ramReadData;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        owner    <= arb_grant;
                        op_write <= sel_we;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                        if (sel_we) begin
                            ramWriteEnable <= 1'b1;
                            ramIndirect    <= 1'b0;
                            ramWriteAddr   <= sel_addr;
                            ramWriteData   <= sel_wdata;
                        end else begin
                            ramReadEnable <= 1'b1;
                            ramIndirect   <= sel_ind;
                            ramReadAddr   <= sel_addr;
                        end
                    end
                end
                ST_ISSUE: begin
                    ramWriteEnable <= 1'b0;
                    ramReadEnable  <= 1'b0;
                    ramIndirect    <= 1'b0;
                    wait_count     <= '0;
                    state          <= op_write ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (finish_op) begin
                        state <= ST_DONE;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    ackA       <= 1'b0;
                    ackB       <= 1'b0;
                    errA       <= 1'b0;
                    errB       <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= owner;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ack_onehot: assert property (@(posedge clk) disable iff (!clr) !(ackA && ackB));

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter with a one-cycle-latency RAM model.
module tb_data_ram_arbiter;

    typedef struct {
        bit         who;
        logic [7:0] rdata;
        bit         err;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       reqA, weA, indA, reqB, weB, indB;
    logic [7:0] addrA, wdataA, addrB, wdataB;
    logic       ackA, errA, ackB, errB, busy;
    logic [7:0] rdataA, rdataB;
    logic       ramWriteEnable, ramReadEnable, ramIndirect;
    logic [7:0] ramReadAddr, ramWriteAddr, ramWriteData;
    logic [7:0] ramReadData;
    logic       ramDataReady;

    logic [47:0] all_outputs;
    logic [7:0]  mem [256];
    logic [7:0]  model_rdata [2];
    bit          stall;
    exp_t        sb [$];
    exp_t        mon_entry;
    exp_t        cont_entry;
    int          compare_count  = 0;
    int          mismatch_count = 0;
    int          cont_n, cont_acks, cont_prev;

    always #5 clk = ~clk;

    data_ram_arbiter #(.width(8), .length(8), .timeout(15)) dut (
        .clk            (clk),
        .clr            (clr),
        .reqA           (reqA),
        .weA            (weA),
        .indA           (indA),
        .addrA          (addrA),
        .wdataA         (wdataA),
        .ackA           (ackA),
        .rdataA         (rdataA),
        .errA           (errA),
        .reqB           (reqB),
        .weB            (weB),
        .indB           (indB),
        .addrB          (addrB),
        .wdataB         (wdataB),
        .ackB           (ackB),
        .rdataB         (rdataB),
        .errB           (errB),
        .busy           (busy),
        .ramWriteEnable (ramWriteEnable),
        .ramReadEnable  (ramReadEnable),
        .ramIndirect    (ramIndirect),
        .ramReadAddr    (ramReadAddr),
        .ramWriteAddr   (ramWriteAddr),
        .ramWriteData   (ramWriteData),
        .ramReadData    (ramReadData),
        .ramDataReady   (ramDataReady)
    );

    assign all_outputs = {ackA, ackB, errA, errB, busy, ramWriteEnable, ramReadEnable,
                          ramIndirect, rdataA, rdataB, ramReadAddr, ramWriteAddr, ramWriteData};

    // RAM answers one cycle after its read enable unless stalled; indirect
    // reads dereference the stored pointer.
    always @(posedge clk) begin
        ramDataReady <= 1'b0;
        if (ramWriteEnable) mem[ramWriteAddr] <= ramWriteData;
        if (ramReadEnable && !stall) begin
            ramDataReady <= 1'b1;
            ramReadData  <= ramIndirect ? mem[mem[ramReadAddr]] : mem[ramReadAddr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ackA === 1'b1 || ackB === 1'b1) begin
            checkOutput("ack_onehot", 64'(ackA & ackB), 64'd0);
            if (sb.size() == 0) begin
                checkOutput("ack_unexpected", 64'd1, 64'd0);
            end else begin
                mon_entry = sb.pop_front();
                checkOutput("ack_who", 64'(ackB), 64'(mon_entry.who));
                checkOutput("ack_rdata", 64'(mon_entry.who ? rdataB : rdataA), 64'(mon_entry.rdata));
                checkOutput("ack_err", 64'(mon_entry.who ? errB : errA), 64'(mon_entry.err));
            end
        end
    end

    task automatic applyStimulus(input bit who, input bit we, input bit ind,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        @(posedge clk);
        #1;
        if (who) begin
            reqB = 1'b1; weB = we; indB = ind; addrB = addr; wdataB = wdata;
        end else begin
            reqA = 1'b1; weA = we; indA = ind; addrA = addr; wdataA = wdata;
        end
    endtask

    task automatic runOp(input string tag, input bit who, input bit we, input bit ind,
                         input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] read_value, input bit exp_err,
                         input int exp_latency);
        int   n;
        bit   got;
        exp_t e;
        if (!we && !exp_err) model_rdata[who] = read_value;
        applyStimulus(who, we, ind, addr, wdata);
        e.who   = who;
        e.rdata = model_rdata[who];
        e.err   = exp_err;
        sb.push_back(e);
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (n == 1) begin
                if (we)
                    checkOutput({tag, "_issue"},
                                64'({busy, ramWriteEnable, ramReadEnable, ramWriteAddr, ramWriteData}),
                                64'({1'b1, 1'b1, 1'b0, addr, wdata}));
                else
                    checkOutput({tag, "_issue"},
                                64'({busy, ramWriteEnable, ramReadEnable, ramIndirect, ramReadAddr}),
                                64'({1'b1, 1'b0, 1'b1, ind, addr}));
                // Operands change after grant; the operation must not notice.
                if (who) begin addrB = ~addr; wdataB = ~wdata; end
                else     begin addrA = ~addr; wdataA = ~wdata; end
            end
            if (n == 2)
                checkOutput({tag, "_enables_low"}, 64'({ramWriteEnable, ramReadEnable}), 64'd0);
            if ((who ? ackB : ackA) === 1'b1) begin
                got = 1;
                checkOutput({tag, "_latency"}, 64'(n), 64'(exp_latency));
            end
            n++;
        end
        if (!got) checkOutput({tag, "_ack_missing"}, 64'd0, 64'd1);
        if (who) reqB = 1'b0; else reqA = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idle"}, 64'({ackA, ackB, busy}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr = 1'b1; stall = 1'b0;
        reqA = 0; weA = 0; indA = 0; addrA = 0; wdataA = 0;
        reqB = 0; weB = 0; indB = 0; addrB = 0; wdataB = 0;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;

        #2 clr = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", 64'(all_outputs), 64'd0);
        clr = 1'b1;

        // Contention straight after reset: A must win the first tie.
        @(posedge clk);
        #1;
        reqA = 1; weA = 1; indA = 0; addrA = 8'h30; wdataA = 8'h11;
        reqB = 1; weB = 1; indB = 0; addrB = 8'h31; wdataB = 8'h22;
        for (int i = 0; i < 4; i++) begin
            cont_entry.who   = (i % 2) == 1;
            cont_entry.rdata = 8'h00;
            cont_entry.err   = 1'b0;
            sb.push_back(cont_entry);
        end
        cont_n = 0; cont_acks = 0; cont_prev = 0;
        while (cont_acks < 4 && cont_n < 40) begin
            @(negedge clk);
            if (ackA === 1'b1 || ackB === 1'b1) begin
                if (cont_acks == 0)
                    checkOutput("contention_first_latency", 64'(cont_n), 64'd2);
                else
                    checkOutput("contention_spacing", 64'(cont_n - cont_prev), 64'd3);
                cont_prev = cont_n;
                cont_acks++;
                if (cont_acks == 4) begin reqA = 0; reqB = 0; end
            end
            cont_n++;
        end
        if (cont_acks < 4) checkOutput("contention_ack_count", 64'(cont_acks), 64'd4);
        reqA = 0; reqB = 0;
        @(negedge clk);
        checkOutput("contention_idle", 64'({ackA, ackB, busy}), 64'd0);

        runOp("single_write", 1'b0, 1'b1, 1'b0, 8'h10, 8'h5A, 8'h00, 1'b0, 2);
        runOp("read_b",       1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 3);
        runOp("preload_ptr",  1'b0, 1'b1, 1'b0, 8'h20, 8'h40, 8'h00, 1'b0, 2);
        runOp("preload_val",  1'b1, 1'b1, 1'b0, 8'h40, 8'h33, 8'h00, 1'b0, 2);
        runOp("indirect_rd",  1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 8'h33, 1'b0, 3);

        stall = 1'b1;
        runOp("timeout_rd",   1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 17);
        stall = 1'b0;
        runOp("read_after_to", 1'b0, 1'b0, 1'b0, 8'h31, 8'h00, 8'h22, 1'b0, 3);

        // Abort a read while it sits in WAIT.
        stall = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("rst_busy_before", 64'(busy), 64'd1);
        clr = 1'b0;
        #1;
        checkOutput("rst_outputs_async", 64'(all_outputs), 64'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_no_ack", 64'({ackA, ackB, busy}), 64'd0);
        end
        clr = 1'b1; reqB = 1'b0; stall = 1'b0;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;

        runOp("read_after_rst",  1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 3);
        runOp("write_after_rst", 1'b0, 1'b1, 1'b0, 8'h50, 8'hC3, 8'h00, 1'b0, 2);
        runOp("read_back",       1'b0, 1'b0, 1'b0, 8'h50, 8'h00, 8'hC3, 1'b0, 3);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 Parameter width, 8, data word width; matches the data RAM.
REQ-002 Parameter length, 8, address width; matches the data RAM.
REQ-003 Parameter timeout, 15, maximum cycles in WAIT before a read is failed; range 1..15.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 clr  in  1  reset; asynchronous, active-low.
REQ-006 reqA / reqB  in  1  request from requester A (CPU) / B (IO); held high until the matching ack.
REQ-007 weA / weB  in  1  1 = write, 0 = read.
REQ-008 indA / indB  in  1  indirect read; ignored when we = 1.
REQ-009 addrA / addrB  in  length  RAM address.
REQ-010 wdataA / wdataB  in  width  write data.
REQ-011 ackA / ackB  out  1  one-cycle completion pulse.
REQ-012 rdataA / rdataB  out  width  read result; valid while ack is high; holds its value afterwards.
REQ-013 errA / errB  out  1  read timed out; valid while ack is high.
REQ-014 busy  out  1  FSM not in IDLE.
REQ-015 ramWriteEnable, ramReadEnable, ramIndirect  out  1  RAM controls; all registered.
REQ-016 ramReadAddr, ramWriteAddr  out  length; ramWriteData  out  width  RAM operands; all registered.
REQ-017 ramReadData  in  width; ramDataReady  in  1  RAM response; the RAM returns data one cycle after its read enable.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE: on an edge where any req is high, select a winner, latch its we, ind, addr and wdata, and go to ISSUE.
REQ-020 Arbitration: single request wins; with both requests high, the requester not granted last wins (round-robin).
REQ-021 ISSUE lasts exactly one cycle and drives the latched command onto the RAM ports. Write: ramWriteEnable = 1, then DONE. Read: ramReadEnable = 1 and ramIndirect = ind, then WAIT.
REQ-022 Outside ISSUE, ramWriteEnable and ramReadEnable are 0. Address and data outputs hold their last value.
REQ-023 WAIT: a 4-bit counter cleared on entry increments each cycle.
REQ-024 In WAIT, ramDataReady = 1 captures ramReadData into the winner's rdata register, clears err, and moves to DONE.
REQ-025 If the counter reaches timeout without ramDataReady, go to DONE with err = 1 and rdata unchanged.
REQ-026 DONE: pulse the winner's ack for exactly one cycle, record the winner as last-granted, and return to IDLE. The loser's ack stays 0.
REQ-027 Latency from the IDLE edge sampling req: write ack at the 2nd following cycle; read ack at the 3rd following cycle with a nominal RAM.
REQ-028 The command is latched at grant. Later changes to req or operands do not affect the operation in flight, and ack still pulses.
REQ-029 Requests arriving in a non-IDLE state wait. Back-to-back throughput is one operation per 3 cycles (write) or 4 cycles (read).
REQ-030 A requester raising req in its own ack cycle is sampled in the following IDLE cycle and is arbitrated normally.
REQ-031 A requester never receives ack without a prior req; at most one ack is high in any cycle.

Reset
REQ-032 clr low, asynchronously: FSM to IDLE, counter to 0, and every output to 0, including rdataA/B and the RAM controls.
REQ-033 Last-granted resets to B, so A wins the first tie.
REQ-034 Reset mid-operation aborts the operation with no ack. A write in ISSUE may or may not complete in the RAM.

Structure
REQ-035 Shared package data_ram_pkg holds the FSM state encoding, the default timeout, and the requester ID constants REQ_A = 0 and REQ_B = 1.
REQ-036 One sub-module, rr_arbiter2: combinational 2-way round-robin pick from reqA, reqB and last-granted, returning a grant ID and a valid flag.
REQ-037 All RAM-facing and requester-facing outputs are registers; no combinational path from any input to any output.

Verification
REQ-038 Single write: reqA, weA = 1, addrA = 0x10, wdataA = 0x5A. Required: ramWriteEnable high one cycle with ramWriteAddr = 0x10 and ramWriteData = 0x5A, then ackA, errA = 0.
REQ-039 Read: reqB, weB = 0, addrB = 0x10, RAM model returns 0x5A. Required: ackB 3 cycles after sampling, rdataB = 0x5A, errB = 0.
REQ-040 Contention: reqA and reqB held high for 4 operations. Required grant order A, B, A, B and no overlapping acks.
REQ-041 Timeout: read with ramDataReady held 0. Required: ackA after 15 WAIT cycles, errA = 1, rdataA unchanged.
REQ-042 Indirect read: indA = 1, RAM model returns 0x33. Required: ramIndirect = 1 during ISSUE, rdataA = 0x33.
REQ-043 Reset in WAIT: clr low for 2 cycles. Required: all outputs 0 immediately, no ack, and the next request is served normally.
